// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx : serial-in / parallel-out word receiver.
//
// A frame opens with a start strobe. WIDTH bits are then collected on
// shift_en strobes, with any number of idle cycles between them. When the
// last bit is sampled, the word is copied into data_out and held there,
// flagged by data_valid, until the consumer acknowledges it.
//
// Parameters
//   WIDTH      serial bits per word (2..32)
//   MSB_FIRST  1: the first bit lands in data_out[WIDTH-1]
//              0: the first bit lands in data_out[0]
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      frame-start strobe (aborts a frame that is in progress)
//   shift_en   bit strobe; serial_in is sampled when high
//   serial_in  serial data bit
//   data_ack   consumer acknowledge of data_out
//   data_out   last completed word (registered)
//   data_valid data_out holds an unacknowledged word
//   busy       a frame is in progress
//   overrun    sticky: a word completed over an unacknowledged word
//   frame_err  one-cycle pulse when start aborts a frame
// ---------------------------------------------------------------------------
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_shift_next;

    // Shift direction decides which end of the word the first bit ends up in.
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[WIDTH-2:0], serial_in};
        end else begin
            w_shift_next = {serial_in, r_shift[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            // Acknowledge clears the flag; a word completing in this same
            // cycle re-sets it below, so the new word is never lost.
            if (data_ack) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RECV;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end

                RECV: begin
                    if (start) begin
                        // Abort and restart: stay in RECV with a fresh word.
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_shift     <= '0;
                    end else if (shift_en) begin
                        if (r_cnt == LAST) begin
                            r_data  <= w_shift_next;
                            r_valid <= 1'b1;
                            if (r_valid && !data_ack) begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_shift <= w_shift_next;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_shift <= w_shift_next;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state == RECV);
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 4, number of serial bits per word (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 means the first received bit is data_out[WIDTH-1], 0 means the first received bit is data_out[0].
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  frame-start strobe; begins a new word.
REQ-006 Port: shift_en  input  1  bit strobe; serial_in is valid when high.
REQ-007 Port: serial_in  input  1  serial data bit.
REQ-008 Port: data_ack  input  1  consumer acknowledge of data_out.
REQ-009 Port: data_out  output  WIDTH  last completed parallel word, registered.
REQ-010 Port: data_valid  output  1  data_out holds an unacknowledged word.
REQ-011 Port: busy  output  1  a frame is in progress (state RECV).
REQ-012 Port: overrun  output  1  sticky flag: a word completed while data_valid was still high.
REQ-013 Port: frame_err  output  1  one-cycle pulse when start arrives in the middle of a frame.

Function
REQ-014 The FSM has exactly two states: IDLE and RECV; busy = (state == RECV).
REQ-015 In IDLE, start=1 moves the FSM to RECV, clears the bit counter and clears the shift register; shift_en and serial_in are ignored in that cycle.
REQ-016 In IDLE with start=0, shift_en is ignored and no state changes.
REQ-017 In RECV, each cycle with shift_en=1 and start=0 samples serial_in into the shift register per MSB_FIRST and increments the bit counter.
REQ-018 Cycles with shift_en=0 in RECV hold all state; arbitrary gaps between bits are legal.
REQ-019 The rising edge that samples bit number WIDTH loads the assembled word into data_out, sets data_valid, and returns the FSM to IDLE; data_out is therefore visible one cycle after the last bit is presented.
REQ-020 data_out holds its value until the next word completes; partial frames never alter data_out.
REQ-021 data_valid clears on the edge where data_ack=1; data_ack while data_valid=0 has no effect.
REQ-022 If a word completes in the same cycle as data_ack=1, data_valid stays 1, data_out takes the new word, and overrun is not set.
REQ-023 If a word completes while data_valid=1 and data_ack=0, data_out is overwritten, data_valid stays 1, and overrun sets; overrun clears only on reset.
REQ-024 start=1 in RECV aborts the current frame: pulse frame_err for one cycle, clear the counter and shift register, and remain in RECV; shift_en in that cycle is ignored.
REQ-025 The bit counter is ceil(log2(WIDTH+1)) bits wide and never exceeds WIDTH.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, busy=0, overrun=0, frame_err=0.
REQ-027 Reset overrides all other inputs in the same cycle, including in mid-frame; a partial word is discarded and data_out is not updated.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1: start, then serial_in 1,0,1,1 on four consecutive shift_en cycles -> data_out=4'b1011, data_valid=1 in the cycle after the 4th bit, busy=0.
REQ-029 Same word with 0-3 idle cycles inserted between bits -> identical data_out=4'b1011; busy=1 throughout the gaps.
REQ-030 Receive 1011 without ack, then receive 1100 -> data_out=4'b1100, data_valid=1, overrun=1; data_ack then clears data_valid and leaves overrun=1.
REQ-031 Send two bits (1,1), then start, then 0,1,0,1 -> frame_err pulses once; data_out=4'b0101.
REQ-032 Assert reset after 2 bits of a frame -> all outputs 0; a following clean frame 0110 yields data_out=4'b0110.
REQ-033 MSB_FIRST=0: start, then bits 1,0,1,1 -> data_out=4'b1101; data_ack in the completion cycle of a second word -> overrun stays 0.
